// File: rtl/ads1115_pkg.sv
// Shared level encodings, default thresholds and LED decode for the ADS1115 level monitor.
package ads1115_pkg;

  typedef enum logic [1:0] {
    LVL_INIT  = 2'b00,
    LVL_OK    = 2'b01,
    LVL_HIGH  = 2'b10,
    LVL_FAULT = 2'b11
  } level_e;

  localparam logic [15:0] DEF_LOW_TH   = 16'h0FA0;
  localparam logic [15:0] DEF_HIGH_TH  = 16'h57E4;
  localparam logic [15:0] DEF_FAULT_TH = 16'h7D00;
  localparam logic [15:0] DEF_HYST     = 16'h0100;
  localparam int          DEF_PERSIST  = 3;

  // Returns {led1, led2, led3}; all active-low, at most one lit.
  function automatic logic [2:0] leds_of(level_e l);
    case (l)
      LVL_OK:    leds_of = 3'b101;
      LVL_HIGH:  leds_of = 3'b110;
      LVL_FAULT: leds_of = 3'b011;
      default:   leds_of = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ads1115_level_monitor_if.sv
// Sample-in / average-and-level-out bundle of the ADS1115 level monitor.
interface ads1115_level_monitor_if;
  // sample_valid and avg_valid are one-cycle strobes with no ready: the consumer
  // must accept every strobe, including on consecutive cycles.
  logic [15:0] sample;
  logic        sample_valid;
  logic [15:0] avg;
  logic        avg_valid;
  logic [1:0]  level;
  logic        led1;
  logic        led2;
  logic        led3;

  modport master (output sample, sample_valid,
                  input  avg, avg_valid, level, led1, led2, led3);
  modport slave  (input  sample, sample_valid,
                  output avg, avg_valid, level, led1, led2, led3);
endinterface

// File: rtl/ads1115_avg4.sv
// 4-sample moving average with warm-up: avg_valid strobes from the 4th accepted sample on.
module ads1115_avg4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic [15:0] avg,
  output logic        avg_valid
);

  logic [3:0][15:0] win_q, win_d;
  logic [17:0]      sum_q, sum_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;

  always_comb begin
    win_d       = win_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (sample_valid) begin
      // The window starts zeroed, so the running sum stays exact during warm-up.
      win_d       = {win_q[2:0], sample};
      sum_d       = sum_q + {2'b00, sample} - {2'b00, win_q[3]};
      avg_d       = sum_d[17:2];
      avg_valid_d = (cnt_q >= 3'd3);
      if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: rtl/ads1115_level_monitor.sv
// ADS1115 level monitor: averaging, threshold classification with hysteresis and persistence, LEDs.
// Optional build macro FAST_FAULT_EN commits a FAULT candidate immediately.
module ads1115_level_monitor
  import ads1115_pkg::*;
#(
  parameter logic [15:0] LOW_TH   = DEF_LOW_TH,
  parameter logic [15:0] HIGH_TH  = DEF_HIGH_TH,
  parameter logic [15:0] FAULT_TH = DEF_FAULT_TH,
  parameter logic [15:0] HYST     = DEF_HYST,
  parameter int          PERSIST  = DEF_PERSIST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ads1115_level_monitor_if.slave   bus
);

  localparam logic [2:0] PERSIST_N = PERSIST[2:0];

  logic [15:0] avg;
  logic        avg_valid;

  ads1115_avg4 u_avg4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (bus.sample),
    .sample_valid (bus.sample_valid),
    .avg          (avg),
    .avg_valid    (avg_valid)
  );

  level_e     level_q, level_d;
  level_e     prev_cand_q, prev_cand_d;
  level_e     raw, cand;
  logic [2:0] pcnt_q, pcnt_d, cnt_next;
  logic       fault_hi_q, fault_hi_d;
  logic [2:0] leds_q, leds_d;

  always_comb begin
    if (avg < LOW_TH || avg > FAULT_TH) raw = LVL_FAULT;
    else if (avg > HIGH_TH)             raw = LVL_HIGH;
    else                                raw = LVL_OK;

    // Hysteresis only delays leaving the committed state, never entering one.
    cand = raw;
    if (level_q == LVL_HIGH && raw == LVL_OK && avg > HIGH_TH - HYST)
      cand = LVL_HIGH;
    if (level_q == LVL_FAULT && raw != LVL_FAULT &&
        (fault_hi_q ? (avg > FAULT_TH - HYST) : (avg < LOW_TH + HYST)))
      cand = LVL_FAULT;
  end

  always_comb begin
    level_d     = level_q;
    prev_cand_d = prev_cand_q;
    pcnt_d      = pcnt_q;
    fault_hi_d  = fault_hi_q;
    cnt_next    = (cand != prev_cand_q) ? 3'd1 : pcnt_q + 3'd1;
    if (avg_valid) begin
      prev_cand_d = cand;
      if (raw == LVL_FAULT) fault_hi_d = (avg > FAULT_TH);
      if (level_q == LVL_INIT) begin
        level_d = cand;
        pcnt_d  = '0;
      end else if (cand == level_q) begin
        pcnt_d = '0;
`ifdef FAST_FAULT_EN
      end else if (cand == LVL_FAULT) begin
        level_d = cand;
        pcnt_d  = '0;
`endif
      end else if (cnt_next == PERSIST_N) begin
        level_d = cand;
        pcnt_d  = '0;
      end else begin
        pcnt_d = cnt_next;
      end
    end
    leds_d = leds_of(level_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q     <= LVL_INIT;
      prev_cand_q <= LVL_INIT;
      pcnt_q      <= '0;
      fault_hi_q  <= 1'b0;
      leds_q      <= 3'b111;
    end else begin
      level_q     <= level_d;
      prev_cand_q <= prev_cand_d;
      pcnt_q      <= pcnt_d;
      fault_hi_q  <= fault_hi_d;
      leds_q      <= leds_d;
    end
  end

  assign bus.avg       = avg;
  assign bus.avg_valid = avg_valid;
  assign bus.level     = level_q;
  assign bus.led1      = leds_q[2];
  assign bus.led2      = leds_q[1];
  assign bus.led3      = leds_q[0];

endmodule

// File: tb/tb_ads1115_level_monitor.sv
// Randomized and directed bench for ads1115_level_monitor against a behavioural level model.
module tb_ads1115_level_monitor;

  localparam int LOW_TH   = 'h0FA0;
  localparam int HIGH_TH  = 'h57E4;
  localparam int FAULT_TH = 'h7D00;
  localparam int HYST     = 'h0100;
  localparam int PERSIST  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ads1115_level_monitor_if bus ();

  ads1115_level_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         hist[$];
  int         n_acc;
  logic [1:0] m_level;
  bit         m_fault_hi;
  logic [1:0] cand_hist[$];
  bit         pend_v;
  int         pend_avg;
  bit         exp_v;
  int         exp_avg;
  bit         avg_known;
  logic [15:0] cur_val;

  function automatic logic [1:0] classify(int a);
    if (a < LOW_TH || a > FAULT_TH) return 2'b11;
    if (a > HIGH_TH) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [2:0] exp_leds(logic [1:0] l);
    case (l)
      2'b01:   return 3'b101;
      2'b10:   return 3'b110;
      2'b11:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Level decision from one average: commit when the last PERSIST candidates
  // since the previous commit all name the same state other than the current one.
  task automatic model_commit(input int a);
    logic [1:0] raw, cand;
    bit run;
    raw  = classify(a);
    cand = raw;
    if (m_level == 2'b10 && raw == 2'b01 && a > HIGH_TH - HYST) cand = 2'b10;
    if (m_level == 2'b11 && raw != 2'b11 &&
        (m_fault_hi ? (a > FAULT_TH - HYST) : (a < LOW_TH + HYST))) cand = 2'b11;
    if (raw == 2'b11) m_fault_hi = (a > FAULT_TH);
    if (m_level == 2'b00) begin
      m_level = cand;
      cand_hist.delete();
      return;
    end
`ifdef FAST_FAULT_EN
    if (cand == 2'b11 && m_level != 2'b11) begin
      m_level = cand;
      cand_hist.delete();
      return;
    end
`endif
    cand_hist.push_back(cand);
    if (cand_hist.size() > PERSIST) void'(cand_hist.pop_front());
    run = (cand != m_level) && (cand_hist.size() == PERSIST);
    foreach (cand_hist[i]) if (cand_hist[i] != cand) run = 0;
    if (run) begin
      m_level = cand;
      cand_hist.delete();
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [15:0] s);
    int sum;
    @(negedge clk);
    rst_n            = ~rst;
    bus.sample_valid = v;
    bus.sample       = s;
    @(posedge clk);
    #1;
    if (rst) begin
      hist.delete(); cand_hist.delete();
      n_acc = 0; m_level = 2'b00; m_fault_hi = 0;
      pend_v = 0; exp_v = 0; exp_avg = 0; avg_known = 1;
    end else begin
      if (pend_v) model_commit(pend_avg);
      pend_v = 0;
      exp_v  = 0;
      if (v) begin
        hist.push_back(int'(s));
        if (hist.size() > 4) void'(hist.pop_front());
        n_acc++;
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        exp_avg   = sum / 4;
        exp_v     = (n_acc >= 4);
        avg_known = exp_v;
        pend_v    = exp_v;
        pend_avg  = exp_avg;
      end
    end
  endtask

  task automatic test_reset();
    step(1, 0, 16'h0);
    step(1, 1, 16'h1234);
    n_checks++;
    if (bus.avg !== 16'h0 || bus.avg_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_avg: got avg=%h v=%b want avg=0000 v=0", bus.avg, bus.avg_valid);
    end
    n_checks++;
    if (bus.level !== 2'b00 || {bus.led1, bus.led2, bus.led3} !== 3'b111) begin
      n_fail++; $display("FAIL reset_level: got level=%b leds=%b want 00/111", bus.level, {bus.led1, bus.led2, bus.led3});
    end
  endtask

  task automatic test_warmup();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h3000);
      n_checks++;
      if (bus.avg_valid !== (i == 3)) begin
        n_fail++; $display("FAIL warmup_valid[%0d]: got %b want %b", i, bus.avg_valid, (i == 3));
      end
    end
    n_checks++;
    if (bus.avg !== 16'h3000) begin
      n_fail++; $display("FAIL warmup_avg: got %h want 3000", bus.avg);
    end
    step(0, 0, 16'h0);
    n_checks++;
    if (bus.level !== 2'b01 || bus.led2 !== 1'b0 || bus.led1 !== 1'b1 || bus.led3 !== 1'b1) begin
      n_fail++; $display("FAIL warmup_level: got level=%b leds=%b want 01/101", bus.level, {bus.led1, bus.led2, bus.led3});
    end
  endtask

  task automatic test_high_persist();
    logic [15:0] want[6] = '{16'h3C00, 16'h4800, 16'h5400, 16'h6000, 16'h6000, 16'h6000};
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 16'h6000);
      n_checks++;
      if (bus.avg_valid !== 1'b1 || bus.avg !== want[i]) begin
        n_fail++; $display("FAIL high_avg[%0d]: got %h v=%b want %h", i, bus.avg, bus.avg_valid, want[i]);
      end
      n_checks++;
      if (bus.level !== 2'b01) begin
        n_fail++; $display("FAIL high_hold[%0d]: got level=%b want 01", i, bus.level);
      end
    end
    step(0, 0, 16'h0);
    n_checks++;
    if (bus.level !== 2'b10 || bus.led3 !== 1'b0) begin
      n_fail++; $display("FAIL high_commit: got level=%b led3=%b want 10/0", bus.level, bus.led3);
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 8; i++) step(0, 1, 16'h5700);
    step(0, 0, 16'h0);
    n_checks++;
    if (bus.level !== 2'b10) begin
      n_fail++; $display("FAIL hyst_hold: got level=%b want 10", bus.level);
    end
    for (int i = 0; i < 6; i++) step(0, 1, 16'h56E4);
    n_checks++;
    if (bus.level !== 2'b10) begin
      n_fail++; $display("FAIL hyst_pre_exit: got level=%b want 10", bus.level);
    end
    step(0, 0, 16'h0);
    n_checks++;
    if (bus.level !== 2'b01 || m_level !== 2'b01) begin
      n_fail++; $display("FAIL hyst_exit: got level=%b model=%b want 01", bus.level, m_level);
    end
  endtask

  task automatic test_fault_low();
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 16'h0100);
      n_checks++;
      if (bus.level !== m_level) begin
        n_fail++; $display("FAIL fault_track[%0d]: got level=%b want %b", i, bus.level, m_level);
      end
    end
    step(0, 0, 16'h0);
    n_checks++;
    if (bus.level !== 2'b11 || {bus.led1, bus.led2, bus.led3} !== 3'b011) begin
      n_fail++; $display("FAIL fault_commit: got level=%b leds=%b want 11/011", bus.level, {bus.led1, bus.led2, bus.led3});
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] vals[5] = '{16'h0FA0, 16'h57E4, 16'h7D00, 16'h8000, 16'h0F9F};
    logic [1:0]  lvls[5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 16'h0);
      for (int i = 0; i < 4; i++) step(0, 1, vals[k]);
      step(0, 0, 16'h0);
      n_checks++;
      if (bus.level !== lvls[k]) begin
        n_fail++; $display("FAIL boundary_%h: got level=%b want %b", vals[k], bus.level, lvls[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(0, 1, 16'h3000);
    step(1, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h4000);
      n_checks++;
      if (bus.avg_valid !== (i == 3) || bus.level !== 2'b00) begin
        n_fail++; $display("FAIL rstmid[%0d]: got v=%b level=%b want v=%b level=00", i, bus.avg_valid, bus.level, (i == 3));
      end
    end
    step(0, 0, 16'h0);
    n_checks++;
    if (bus.level !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_commit: got level=%b want 01", bus.level);
    end
  endtask

  function automatic logic [15:0] pick_value();
    int base;
    case ($urandom_range(0, 5))
      0:       base = LOW_TH;
      1:       base = HIGH_TH;
      2:       base = FAULT_TH;
      3:       base = HIGH_TH - HYST;
      4:       base = LOW_TH + HYST;
      default: return 16'($urandom_range(0, 'hFFFF));
    endcase
    return 16'(base + int'($urandom_range(0, 'h180)) - 'hC0);
  endfunction

  task automatic test_random();
    bit rst, v;
    cur_val = 16'h3000;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) cur_val = pick_value();
      step(rst, v, cur_val);
      n_checks++;
      if (bus.avg_valid !== exp_v) begin
        n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.avg_valid, exp_v);
      end
      if (avg_known) begin
        n_checks++;
        if (bus.avg !== 16'(exp_avg)) begin
          n_fail++; $display("FAIL rnd_avg@%0d: got %h want %h", c, bus.avg, 16'(exp_avg));
        end
      end
      n_checks++;
      if (bus.level !== m_level || {bus.led1, bus.led2, bus.led3} !== exp_leds(m_level)) begin
        n_fail++; $display("FAIL rnd_level@%0d: got level=%b leds=%b want %b/%b", c, bus.level,
                           {bus.led1, bus.led2, bus.led3}, m_level, exp_leds(m_level));
      end
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.sample       = '0;
    bus.sample_valid = 1'b0;
    test_reset();
    test_warmup();
    test_high_persist();
    test_hysteresis();
    test_fault_low();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
